i2c_bus_monitor: RTL and testbench

- Passive I2C bus monitor for the audio-codec configuration bus. It watches SCL/SDA, including the lines bit-banged by the Nios debug PIO, and decodes START, STOP, data bytes and ACK bits.
- Each decoded event is pushed into a small FIFO. The CPU pops the FIFO over an Avalon-MM slave port.
- It is the reader side of the software-driven I2C writer and never drives the bus.

---
 rtl/i2c_bus_monitor.sv | 173 +++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor. Decodes START, STOP, data bytes and ACK bits from
// asynchronous SCL/SDA and queues 11-bit event records for an Avalon-MM reader.
// Never drives the bus.
module i2c_bus_monitor #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StShift, StAck} state_e;

  // Synchronizer, current and history samples; reset to an idle (high) bus.
  logic scl_meta_q, scl_cur_q, scl_prev_q;
  logic sda_meta_q, sda_cur_q, sda_prev_q;

  // Decoder state.
  state_e      state_q;
  logic [3:0]  bitcnt_q;
  logic        first_q;
  logic [7:0]  shreg_q;
  logic        push_q;
  logic [10:0] rec_q;
  logic        trunc_q;

  // Record FIFO.
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  logic start_ev, stop_ev, bit_ev;
  logic valid, full, pop, push_ok;
  logic ovf_clr, trunc_clr;
  logic unused_wdata;

  // Two-flop synchronizers followed by one history flop per line.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_cur_q  <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_cur_q  <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_cur_q  <= scl_meta_q;
      scl_prev_q <= scl_cur_q;
      sda_meta_q <= sda;
      sda_cur_q  <= sda_meta_q;
      sda_prev_q <= sda_cur_q;
    end
  end

  // Bus conditions: START/STOP need SCL high in both samples, so simultaneous
  // SCL/SDA changes can only ever be a bit sample.
  always_comb begin
    start_ev = scl_cur_q & scl_prev_q & sda_prev_q & ~sda_cur_q;
    stop_ev  = scl_cur_q & scl_prev_q & ~sda_prev_q & sda_cur_q;
    bit_ev   = ~scl_prev_q & scl_cur_q;
  end

  // Avalon decode for the control side.
  always_comb begin
    valid        = (count_q != '0);
    full         = (count_q == CW'(FIFO_DEPTH));
    pop          = chipselect & ~read_n & (address == 2'd0) & valid;
    push_ok      = push_q & (~full | pop);
    ovf_clr      = chipselect & ~write_n & (address == 2'd1) & writedata[8];
    trunc_clr    = chipselect & ~write_n & (address == 2'd1) & writedata[9];
    unused_wdata = ^{writedata[31:10], writedata[7:0]};
  end

  // Frame decoder FSM; record and push strobe are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      bitcnt_q <= 4'd0;
      first_q  <= 1'b0;
      shreg_q  <= 8'h00;
      push_q   <= 1'b0;
      rec_q    <= 11'h000;
      trunc_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // Clear first so a set in the same cycle takes precedence.
      if (trunc_clr) trunc_q <= 1'b0;
      if (stop_ev) begin
        push_q <= 1'b1;
        rec_q  <= 11'h400;
        if (state_q == StAck || bitcnt_q != 4'd0) trunc_q <= 1'b1;
        state_q  <= StIdle;
        bitcnt_q <= 4'd0;
        first_q  <= 1'b0;
      end else if (start_ev) begin
        if (state_q != StIdle && (state_q == StAck || bitcnt_q != 4'd0)) trunc_q <= 1'b1;
        state_q  <= StShift;
        bitcnt_q <= 4'd0;
        first_q  <= 1'b1;
      end else if (bit_ev) begin
        unique case (state_q)
          StIdle: ;
          StShift: begin
            shreg_q  <= {shreg_q[6:0], sda_cur_q};
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) state_q <= StAck;
          end
          StAck: begin
            push_q   <= 1'b1;
            rec_q    <= {1'b0, first_q, sda_cur_q, shreg_q};
            first_q  <= 1'b0;
            bitcnt_q <= 4'd0;
            state_q  <= StShift;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rec_q;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      if (ovf_clr)            ovf_q <= 1'b0;
      if (push_q && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0: if (valid) readdata = {1'b1, 20'b0, mem_q[rd_ptr_q]};
      2'd1: begin
        readdata[CW-1:0] = count_q;
        readdata[8]      = ovf_q;
        readdata[9]      = trunc_q;
        readdata[10]     = (state_q != StIdle);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor: bit-banged I2C frames with fixed phase
// lengths, Avalon peeks/pops, hand-computed expected records and status words.
module tb_i2c_bus_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        sda = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;

  int total = 0;
  int bad = 0;
  logic [31:0] op_rd;

  i2c_bus_monitor #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda        (sda),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive pins, hold 4 clocks. op=1 pops and op=2 writes 0x100 to addr 1 on
  // the 4th edge, which is the edge where a record caused by this pin change
  // reaches the FIFO.
  task automatic set_bus(input logic s, input logic d, input int op = 0);
    scl = s;
    sda = d;
    tick();
    tick();
    tick();
    if (op == 1) begin
      address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    end else if (op == 2) begin
      address = 2'd1; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h100;
    end
    #1;
    op_rd = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic pop(output logic [31:0] d);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    #1;
    d = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wr1(input logic [31:0] v);
    address = 2'd1; chipselect = 1'b1; write_n = 1'b0; writedata = v;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic i2c_start();
    if (!(scl && sda)) begin
      set_bus(1'b0, sda);
      set_bus(1'b0, 1'b1);
      set_bus(1'b1, 1'b1);
    end
    set_bus(1'b1, 1'b0);
  endtask

  task automatic send_bit(input logic b, input int op = 0);
    set_bus(1'b0, sda);
    set_bus(1'b0, b);
    set_bus(1'b1, b, op);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack, input int ack_op = 0);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    send_bit(ack, ack_op);
  endtask

  // After an ACK (SCL high, SDA low) the STOP follows directly.
  task automatic i2c_stop(input int op = 0);
    if (!(scl && !sda)) begin
      set_bus(1'b0, sda);
      set_bus(1'b0, 1'b0);
      set_bus(1'b1, 1'b0);
    end
    set_bus(1'b1, 1'b1, op);
  endtask

  task automatic frame(input logic [7:0] v);
    i2c_start();
    send_byte(v, 1'b0);
    i2c_stop();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    peek(2'd0, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL reset_addr0 got=%08h exp=%08h", d, 32'h0); bad++; end
    peek(2'd1, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL reset_addr1 got=%08h exp=%08h", d, 32'h0); bad++; end
    peek(2'd2, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL reset_addr2 got=%08h exp=%08h", d, 32'h0); bad++; end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    set_bus(1'b0, 1'b0);
    set_bus(1'b1, 1'b1);
    set_bus(1'b0, 1'b0);
    set_bus(1'b1, 1'b1);
    peek(2'd1, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL glitch_status got=%08h exp=%08h", d, 32'h0); bad++; end
    peek(2'd0, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL glitch_fifo got=%08h exp=%08h", d, 32'h0); bad++; end
  endtask

  task automatic test_write_txn();
    logic [31:0] d;
    logic [31:0] exp [4];
    exp = '{32'h80000234, 32'h8000001E, 32'h80000100, 32'h80000400};
    i2c_start();
    send_byte(8'h34, 1'b0);
    send_byte(8'h1E, 1'b0);
    send_byte(8'h00, 1'b1);
    i2c_stop();
    peek(2'd1, d);
    total++;
    if (d[3:0] !== 4'd4 || d[10] !== 1'b0 || d[8] !== 1'b0) begin
      $display("FAIL txn_status got=%08h exp count=4 busy=0 ovf=0", d); bad++;
    end
    wr1(32'h300);
    for (int i = 0; i < 4; i++) begin
      pop(d);
      total++;
      if (d !== exp[i]) begin $display("FAIL txn_pop%0d got=%08h exp=%08h", i, d, exp[i]); bad++; end
    end
    pop(d);
    total++;
    if (d !== 32'h0) begin $display("FAIL txn_pop_empty got=%08h exp=%08h", d, 32'h0); bad++; end
    peek(2'd1, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL txn_status_clr got=%08h exp=%08h", d, 32'h0); bad++; end
  endtask

  task automatic test_rep_start();
    logic [31:0] d;
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_start();
    send_byte(8'hA5, 1'b0);
    i2c_stop();
    peek(2'd1, d);
    total++;
    if (d !== 32'h202) begin $display("FAIL rs_status got=%08h exp=%08h", d, 32'h202); bad++; end
    wr1(32'h200);
    peek(2'd1, d);
    total++;
    if (d !== 32'h002) begin $display("FAIL rs_trunc_clr got=%08h exp=%08h", d, 32'h002); bad++; end
    pop(d);
    total++;
    if (d !== 32'h800002A5) begin $display("FAIL rs_pop0 got=%08h exp=%08h", d, 32'h800002A5); bad++; end
    pop(d);
    total++;
    if (d !== 32'h80000400) begin $display("FAIL rs_pop1 got=%08h exp=%08h", d, 32'h80000400); bad++; end
    peek(2'd0, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL rs_empty got=%08h exp=%08h", d, 32'h0); bad++; end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 0; i < 9; i++) frame(8'h55);
    peek(2'd1, d);
    total++;
    if (d !== 32'h108) begin $display("FAIL ovf_status got=%08h exp=%08h", d, 32'h108); bad++; end
    for (int i = 0; i < 8; i++) begin
      e = (i % 2 == 0) ? 32'h80000255 : 32'h80000400;
      pop(d);
      total++;
      if (d !== e) begin $display("FAIL ovf_pop%0d got=%08h exp=%08h", i, d, e); bad++; end
    end
    peek(2'd0, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL ovf_empty got=%08h exp=%08h", d, 32'h0); bad++; end
    wr1(32'h100);
    peek(2'd1, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL ovf_clr got=%08h exp=%08h", d, 32'h0); bad++; end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] exp [8];
    exp = '{32'h80000400, 32'h80000222, 32'h80000400, 32'h80000233,
            32'h80000400, 32'h80000244, 32'h80000400, 32'h80000299};
    frame(8'h11);
    frame(8'h22);
    frame(8'h33);
    frame(8'h44);
    peek(2'd1, d);
    total++;
    if (d !== 32'h008) begin $display("FAIL b2b_full got=%08h exp=%08h", d, 32'h008); bad++; end
    // Pop on the exact cycle the 0x99 record is pushed into the full FIFO.
    i2c_start();
    send_byte(8'h99, 1'b0, 1);
    total++;
    if (op_rd !== 32'h80000211) begin
      $display("FAIL b2b_popped got=%08h exp=%08h", op_rd, 32'h80000211); bad++;
    end
    peek(2'd1, d);
    total++;
    if (d !== 32'h408) begin $display("FAIL b2b_push_pop got=%08h exp=%08h", d, 32'h408); bad++; end
    // Dropped STOP sets ovf on the same edge as a W1C; the set must win.
    i2c_stop(2);
    peek(2'd1, d);
    total++;
    if (d !== 32'h108) begin $display("FAIL b2b_set_vs_clr got=%08h exp=%08h", d, 32'h108); bad++; end
    for (int i = 0; i < 8; i++) begin
      pop(d);
      total++;
      if (d !== exp[i]) begin $display("FAIL b2b_pop%0d got=%08h exp=%08h", i, d, exp[i]); bad++; end
    end
    wr1(32'h100);
    peek(2'd1, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL b2b_final got=%08h exp=%08h", d, 32'h0); bad++; end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    i2c_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    set_bus(1'b0, 1'b0);
    peek(2'd1, d);
    total++;
    if (d[10] !== 1'b1) begin $display("FAIL mid_busy got=%0b exp=1", d[10]); bad++; end
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    peek(2'd1, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL mid_status got=%08h exp=%08h", d, 32'h0); bad++; end
    peek(2'd0, d);
    total++;
    if (d !== 32'h0) begin $display("FAIL mid_fifo got=%08h exp=%08h", d, 32'h0); bad++; end
    // Release SDA while SCL low, then SCL: the rise is ignored in idle.
    set_bus(1'b0, 1'b1);
    set_bus(1'b1, 1'b1);
    frame(8'h6C);
    peek(2'd1, d);
    total++;
    if (d !== 32'h002) begin $display("FAIL mid_after got=%08h exp=%08h", d, 32'h002); bad++; end
    pop(d);
    total++;
    if (d !== 32'h8000026C) begin $display("FAIL mid_pop0 got=%08h exp=%08h", d, 32'h8000026C); bad++; end
    pop(d);
    total++;
    if (d !== 32'h80000400) begin $display("FAIL mid_pop1 got=%08h exp=%08h", d, 32'h80000400); bad++; end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_write_txn();
    test_rep_start();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
